ibm_job_responder: RTL and testbench

// Network-side endpoint of the IBM Quantum job interface. Accepts job submissions (id + backend) from the

---
 rtl/ibm_job_responder.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_ibm_job_responder.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibm_job_responder.sv
// ibm_job_responder
// Network-side endpoint of the IBM Quantum job interface. Submitted jobs (id + backend)
// are queued in a small FIFO. Each job is sent as a 6-byte request frame on the byte link.
// The matching result frame is then collected, and the measurement vector is returned with
// a one-cycle ibm_job_complete pulse.
//
// Optional feature macro: IBM_JOB_TIMEOUT_EN
//   When defined, an rx inactivity counter aborts a job after TIMEOUT_CYCLES silent cycles
//   and pulses job_timeout. When undefined, job_timeout is constant 0 and rx waits forever.
//
// Handshakes:
//   link_tx: a byte transfers on a cycle with link_tx_valid && link_tx_ready. Once raised,
//   valid stays high and link_tx_data stays stable until that byte transfers.
//   link_rx: there is no backpressure. Every cycle with link_rx_valid delivers one byte.
module ibm_job_responder #(
    parameter int CLASSICAL_BITS = 133,
    parameter int JOB_FIFO_DEPTH = 4
`ifdef IBM_JOB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1_000_000
`endif
) (
    input  logic                      clk_100mhz,
    input  logic                      reset,
    input  logic [31:0]               ibm_job_id,
    input  logic [7:0]                ibm_backend_select,
    input  logic                      ibm_submit_pulse,
    output logic                      ibm_job_complete,
    output logic [CLASSICAL_BITS-1:0] ibm_measurement_result,
    output logic                      job_queue_full,
    output logic                      submit_dropped,
    output logic [7:0]                link_tx_data,
    output logic                      link_tx_valid,
    input  logic                      link_tx_ready,
    input  logic [7:0]                link_rx_data,
    input  logic                      link_rx_valid,
    output logic                      job_timeout,
    output logic                      busy
);

    localparam int RESULT_BYTES = (CLASSICAL_BITS + 7) / 8;
    localparam int AW = (JOB_FIFO_DEPTH > 1) ? $clog2(JOB_FIFO_DEPTH) : 1;
    localparam int CW = (RESULT_BYTES > 4) ? $clog2(RESULT_BYTES) : 2;

    localparam logic [AW:0]   FIFO_FULL = (AW + 1)'(JOB_FIFO_DEPTH);
    localparam logic [CW-1:0] ID_LAST   = CW'(3);
    localparam logic [CW-1:0] DATA_LAST = CW'(RESULT_BYTES - 1);
    localparam logic [2:0]    TX_LAST   = 3'd5;
    localparam logic [7:0]    TX_SOF    = 8'hA5;
    localparam logic [7:0]    RX_SOF    = 8'h5A;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_TX      = 3'd1,
        S_RX_HDR  = 3'd2,
        S_RX_ID   = 3'd3,
        S_RX_DATA = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t state;
    state_t state_next;

    // Job FIFO storage: {backend, id}
    logic [39:0]   fifo_mem [JOB_FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   fifo_count;
    logic          fifo_empty;
    logic          push;
    logic          pop;

    // Current job and frame progress
    logic [31:0]               cur_id;
    logic [7:0]                cur_backend;
    logic [2:0]                tx_idx;
    logic [CW-1:0]             rx_cnt;
    logic                      id_ok;
    logic [7:0]                id_byte;
    logic [CLASSICAL_BITS-1:0] shadow;
    logic                      tx_fire;
    logic                      timeout_hit;

    assign fifo_empty     = (fifo_count == '0);
    assign job_queue_full = (fifo_count == FIFO_FULL);
    // A pop in the same cycle frees a slot, so a submit into a full queue is still accepted.
    assign push           = ibm_submit_pulse && (!job_queue_full || pop);
    assign link_tx_valid  = (state == S_TX);
    assign busy           = (state != S_IDLE) || !fifo_empty;

    // FIFO pointers, occupancy and the drop indication
    always_ff @(posedge clk_100mhz or posedge reset) begin
        if (reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fifo_count     <= '0;
            submit_dropped <= 1'b0;
        end else begin
            submit_dropped <= ibm_submit_pulse && !push;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + 1'b1;
            end else if (pop && !push) begin
                fifo_count <= fifo_count - 1'b1;
            end
        end
    end

    // FIFO storage is not reset; occupancy alone defines the valid entries
    always_ff @(posedge clk_100mhz) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {ibm_backend_select, ibm_job_id};
        end
    end

    // Request byte select for the 6-byte frame
    always_comb begin
        link_tx_data = 8'h00;
        case (tx_idx)
            3'd0:    link_tx_data = TX_SOF;
            3'd1:    link_tx_data = cur_backend;
            3'd2:    link_tx_data = cur_id[31:24];
            3'd3:    link_tx_data = cur_id[23:16];
            3'd4:    link_tx_data = cur_id[15:8];
            3'd5:    link_tx_data = cur_id[7:0];
            default: link_tx_data = 8'h00;
        endcase
    end

    // Expected id byte for the current RX_ID position (MSB first)
    always_comb begin
        id_byte = 8'h00;
        case (rx_cnt[1:0])
            2'd0:    id_byte = cur_id[31:24];
            2'd1:    id_byte = cur_id[23:16];
            2'd2:    id_byte = cur_id[15:8];
            default: id_byte = cur_id[7:0];
        endcase
    end

`ifdef IBM_JOB_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] to_cnt;
    logic          in_rx;

    assign in_rx       = (state == S_RX_HDR) || (state == S_RX_ID) || (state == S_RX_DATA);
    assign timeout_hit = in_rx && !link_rx_valid && (to_cnt == TO_LAST);

    // Rx inactivity counter: zeroed while sending (so it starts at 0 in RX_HDR) and on each rx byte
    always_ff @(posedge clk_100mhz or posedge reset) begin
        if (reset) begin
            to_cnt <= '0;
        end else if (state == S_TX) begin
            to_cnt <= '0;
        end else if (in_rx) begin
            if (link_rx_valid || timeout_hit) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
        end else begin
            to_cnt <= '0;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_100mhz or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and per-cycle control strobes
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        tx_fire    = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = S_TX;
                end
            end
            S_TX: begin
                if (link_tx_ready) begin
                    tx_fire = 1'b1;
                    if (tx_idx == TX_LAST) begin
                        state_next = S_RX_HDR;
                    end
                end
            end
            S_RX_HDR: begin
                if (link_rx_valid && (link_rx_data == RX_SOF)) begin
                    state_next = S_RX_ID;
                end
            end
            S_RX_ID: begin
                // The whole 4-byte id is consumed before a mismatching frame is dropped
                if (link_rx_valid && (rx_cnt == ID_LAST)) begin
                    if (id_ok && (link_rx_data == id_byte)) begin
                        state_next = S_RX_DATA;
                    end else begin
                        state_next = S_RX_HDR;
                    end
                end
            end
            S_RX_DATA: begin
                if (link_rx_valid && (rx_cnt == DATA_LAST)) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        if (timeout_hit) begin
            state_next = S_IDLE;
        end
    end

    // Job capture, frame counters, result shadow and the result/complete outputs
    always_ff @(posedge clk_100mhz or posedge reset) begin
        if (reset) begin
            cur_id                 <= '0;
            cur_backend            <= '0;
            tx_idx                 <= '0;
            rx_cnt                 <= '0;
            id_ok                  <= 1'b0;
            shadow                 <= '0;
            ibm_measurement_result <= '0;
            ibm_job_complete       <= 1'b0;
            job_timeout            <= 1'b0;
        end else begin
            ibm_job_complete <= 1'b0;
            job_timeout      <= timeout_hit;
            if (pop) begin
                cur_id      <= fifo_mem[rd_ptr][31:0];
                cur_backend <= fifo_mem[rd_ptr][39:32];
                tx_idx      <= '0;
            end
            if (tx_fire) begin
                tx_idx <= (tx_idx == TX_LAST) ? 3'd0 : tx_idx + 3'd1;
            end
            if (link_rx_valid) begin
                case (state)
                    S_RX_HDR: begin
                        if (link_rx_data == RX_SOF) begin
                            rx_cnt <= '0;
                            id_ok  <= 1'b1;
                        end
                    end
                    S_RX_ID: begin
                        if (link_rx_data != id_byte) begin
                            id_ok <= 1'b0;
                        end
                        rx_cnt <= (rx_cnt == ID_LAST) ? '0 : rx_cnt + 1'b1;
                    end
                    S_RX_DATA: begin
                        // LS byte first; bits past CLASSICAL_BITS in the last byte fall away
                        for (int i = 0; i < CLASSICAL_BITS; i++) begin
                            if (rx_cnt == CW'(i / 8)) begin
                                shadow[i] <= link_rx_data[3'(i % 8)];
                            end
                        end
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
            if (state == S_DONE) begin
                ibm_measurement_result <= shadow;
                ibm_job_complete       <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ibm_job_responder.sv
// tb_ibm_job_responder
// Drives job submits and rx frames. A negedge monitor pops expected tx bytes and expected
// results from scoreboard queues. Define IBM_JOB_TIMEOUT_EN to include the rx timeout phase.
`timescale 1ns/1ps
module tb_ibm_job_responder;

    localparam int CB = 133;
    localparam int RB = (CB + 7) / 8;

    logic          clk_100mhz;
    logic          reset;
    logic [31:0]   ibm_job_id;
    logic [7:0]    ibm_backend_select;
    logic          ibm_submit_pulse;
    logic          ibm_job_complete;
    logic [CB-1:0] ibm_measurement_result;
    logic          job_queue_full;
    logic          submit_dropped;
    logic [7:0]    link_tx_data;
    logic          link_tx_valid;
    logic          link_tx_ready;
    logic [7:0]    link_rx_data;
    logic          link_rx_valid;
    logic          job_timeout;
    logic          busy;

    logic [7:0]    tx_q[$];
    logic [CB-1:0] exp_q[$];

    int cmp_cnt = 0;
    int err_cnt = 0;
    int n_complete = 0;
    int n_timeouts = 0;
    int exp_timeouts = 0;
    int ready_mode = 1;    // 0: hold low, 1: hold high, 2: toggle every cycle

    ibm_job_responder #(
        .CLASSICAL_BITS(CB),
        .JOB_FIFO_DEPTH(4)
`ifdef IBM_JOB_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(100)
`endif
    ) dut (
        .clk_100mhz            (clk_100mhz),
        .reset                 (reset),
        .ibm_job_id            (ibm_job_id),
        .ibm_backend_select    (ibm_backend_select),
        .ibm_submit_pulse      (ibm_submit_pulse),
        .ibm_job_complete      (ibm_job_complete),
        .ibm_measurement_result(ibm_measurement_result),
        .job_queue_full        (job_queue_full),
        .submit_dropped        (submit_dropped),
        .link_tx_data          (link_tx_data),
        .link_tx_valid         (link_tx_valid),
        .link_tx_ready         (link_tx_ready),
        .link_rx_data          (link_rx_data),
        .link_rx_valid         (link_rx_valid),
        .job_timeout           (job_timeout),
        .busy                  (busy)
    );

    // Clock and watchdog
    initial begin
        clk_100mhz = 1'b0;
        forever #5 clk_100mhz = ~clk_100mhz;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [CB-1:0] got, input logic [CB-1:0] exp);
        cmp_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_100mhz);
        #1;
    endtask

    task automatic set_submit(input logic [31:0] id, input logic [7:0] be, input logic en);
        ibm_job_id         = id;
        ibm_backend_select = be;
        ibm_submit_pulse   = en;
    endtask

    task automatic push_tx(input logic [31:0] id, input logic [7:0] be);
        tx_q.push_back(8'hA5);
        tx_q.push_back(be);
        tx_q.push_back(id[31:24]);
        tx_q.push_back(id[23:16]);
        tx_q.push_back(id[15:8]);
        tx_q.push_back(id[7:0]);
    endtask

    task automatic send_byte(input logic [7:0] b);
        link_rx_valid = 1'b1;
        link_rx_data  = b;
        tick();
        link_rx_valid = 1'b0;
    endtask

    // mode 0: data bytes 1,2,3,...; mode 1: random data bytes
    task automatic send_frame(input logic [31:0] id, input int mode, input int n_data,
                              input bit expect_ok);
        logic [8*RB-1:0] model;
        logic [7:0]      b;
        model = '0;
        send_byte(8'h5A);
        for (int k = 3; k >= 0; k--) begin
            send_byte(id[8*k +: 8]);
        end
        for (int j = 0; j < n_data; j++) begin
            b = (mode == 0) ? 8'(j + 1) : 8'($urandom_range(0, 255));
            model[8*j +: 8] = b;
            send_byte(b);
        end
        if (expect_ok) begin
            exp_q.push_back(model[CB-1:0]);
        end
    endtask

    task automatic wait_tx_done(input string tag);
        int   n;
        logic saw;
        n = 0;
        while (!link_tx_valid && n < 200) begin
            @(negedge clk_100mhz);
            n++;
        end
        saw = link_tx_valid;
        while (link_tx_valid && n < 400) begin
            @(negedge clk_100mhz);
            n++;
        end
        check(tag, {saw, link_tx_valid}, 2'b10);
    endtask

    task automatic wait_complete(input string tag);
        int n;
        n = 0;
        @(negedge clk_100mhz);
        while (!ibm_job_complete && n < 100) begin
            @(negedge clk_100mhz);
            n++;
        end
        check(tag, ibm_job_complete, 1'b1);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        @(negedge clk_100mhz);
        while (busy && n < 300) begin
            @(negedge clk_100mhz);
            n++;
        end
        check(tag, busy, 1'b0);
    endtask

    // Link ready driver
    initial begin
        link_tx_ready = 1'b0;
        forever begin
            @(posedge clk_100mhz);
            #1;
            case (ready_mode)
                0:       link_tx_ready = 1'b0;
                1:       link_tx_ready = 1'b1;
                default: link_tx_ready = ~link_tx_ready;
            endcase
        end
    end

    // Scoreboard monitor: tx bytes, stall stability, completes, timeouts
    initial begin
        logic       pv;
        logic       pr;
        logic       pc;
        logic [7:0] pd;
        pv = 1'b0;
        pr = 1'b0;
        pc = 1'b0;
        pd = 8'h00;
        forever begin
            @(negedge clk_100mhz);
            if (!reset) begin
                if (link_tx_valid && pv && !pr) begin
                    check("tx_stable", link_tx_data, pd);
                end
                if (link_tx_valid && link_tx_ready) begin
                    check("tx_pending", tx_q.size() != 0, 1'b1);
                    if (tx_q.size() != 0) begin
                        check("tx_byte", link_tx_data, tx_q.pop_front());
                    end
                end
                if (ibm_job_complete) begin
                    n_complete++;
                    check("complete_single", pc, 1'b0);
                    check("complete_pending", exp_q.size() != 0, 1'b1);
                    if (exp_q.size() != 0) begin
                        check("result", ibm_measurement_result, exp_q.pop_front());
                    end
                end
                if (job_timeout) begin
                    n_timeouts++;
                end
            end
            pv = link_tx_valid;
            pr = link_tx_ready;
            pd = link_tx_data;
            pc = ibm_job_complete;
        end
    end

    // Main stimulus
    initial begin
        reset = 1'b1;
        set_submit(32'h0, 8'h0, 1'b0);
        link_rx_valid = 1'b0;
        link_rx_data  = 8'h00;
        ready_mode    = 1;
        repeat (2) @(posedge clk_100mhz);
        @(negedge clk_100mhz);
        check("rst_complete", ibm_job_complete, 1'b0);
        check("rst_result", ibm_measurement_result, '0);
        check("rst_full", job_queue_full, 1'b0);
        check("rst_dropped", submit_dropped, 1'b0);
        check("rst_tx_valid", link_tx_valid, 1'b0);
        check("rst_timeout", job_timeout, 1'b0);
        check("rst_busy", busy, 1'b0);
        tick();
        reset = 1'b0;

        // Phase A: single job, latency and exact byte stream, then result frame
        tick();
        set_submit(32'h0000_1234, 8'h01, 1'b1);
        push_tx(32'h0000_1234, 8'h01);
        @(negedge clk_100mhz);
        check("lat_c0", link_tx_valid, 1'b0);
        tick();
        set_submit(32'h0, 8'h0, 1'b0);
        @(negedge clk_100mhz);
        check("lat_c1", link_tx_valid, 1'b0);
        check("busy_c1", busy, 1'b1);
        @(negedge clk_100mhz);
        check("lat_c2", link_tx_valid, 1'b1);
        check("first_byte", link_tx_data, 8'hA5);
        repeat (5) begin
            @(negedge clk_100mhz);
            check("tx_burst", link_tx_valid, 1'b1);
        end
        @(negedge clk_100mhz);
        check("tx_end", link_tx_valid, 1'b0);
        send_frame(32'h0000_1234, 0, RB, 1'b1);
        wait_complete("cmp_a");
        check("res_lo", ibm_measurement_result[7:0], 8'h01);
        check("res_hi", ibm_measurement_result[CB-1:128], 5'h11);

        // Phase B: fill the queue behind a stalled job, then drain with a toggling ready
        ready_mode = 0;
        tick();
        tick();
        set_submit(32'hA000_0000, 8'h10, 1'b1);
        push_tx(32'hA000_0000, 8'h10);
        tick();
        set_submit(32'h0, 8'h0, 1'b0);
        for (int n = 0; n < 20 && !link_tx_valid; n++) begin
            @(negedge clk_100mhz);
        end
        check("b_tx_start", link_tx_valid, 1'b1);
        tick();
        for (int i = 1; i <= 5; i++) begin
            set_submit(32'(32'hA000_0000 + i), 8'(8'h10 + i), 1'b1);
            if (i <= 4) begin
                push_tx(32'(32'hA000_0000 + i), 8'(8'h10 + i));
            end
            tick();
            check("full", job_queue_full, i >= 4);
            check("dropped", submit_dropped, i == 5);
        end
        set_submit(32'h0, 8'h0, 1'b0);
        tick();
        check("dropped_clear", submit_dropped, 1'b0);
        check("full_hold", job_queue_full, 1'b1);
        check("stall_valid", link_tx_valid, 1'b1);

        ready_mode = 2;
        wait_tx_done("tx_j0");
        send_frame(32'hA000_0000, 1, RB, 1'b1);
        wait_complete("cmp_j0");
        // Still in the IDLE cycle with a full queue: this submit lands on the pop edge
        set_submit(32'hA000_0006, 8'h16, 1'b1);
        push_tx(32'hA000_0006, 8'h16);
        tick();
        set_submit(32'h0, 8'h0, 1'b0);
        check("full_after_swap", job_queue_full, 1'b1);
        check("drop_after_swap", submit_dropped, 1'b0);

        wait_tx_done("tx_j1");
        send_frame(32'hDEAD_BEEF, 0, RB, 1'b0);
        send_frame(32'hA000_0001, 1, RB, 1'b1);
        for (int i = 2; i <= 4; i++) begin
            wait_tx_done("tx_jn");
            send_frame(32'(32'hA000_0000 + i), 1, RB, 1'b1);
        end
        wait_tx_done("tx_j6");
        send_frame(32'hA000_0006, 1, RB, 1'b1);
        wait_idle("idle_b");
        check("full_drained", job_queue_full, 1'b0);

        // Phase C: reset in the middle of RX_DATA
        ready_mode = 1;
        tick();
        set_submit(32'h0C0F_FEE0, 8'h22, 1'b1);
        push_tx(32'h0C0F_FEE0, 8'h22);
        tick();
        set_submit(32'h0, 8'h0, 1'b0);
        wait_tx_done("tx_rst");
        send_frame(32'h0C0F_FEE0, 1, 8, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_valid", link_tx_valid, 1'b0);
        check("mid_rst_complete", ibm_job_complete, 1'b0);
        check("mid_rst_result", ibm_measurement_result, '0);
        check("mid_rst_busy", busy, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        for (int j = 0; j < 9; j++) begin
            send_byte(8'($urandom_range(0, 255)));
        end
        repeat (20) @(negedge clk_100mhz);
        check("post_rst_busy", busy, 1'b0);
        check("post_rst_result", ibm_measurement_result, '0);

`ifdef IBM_JOB_TIMEOUT_EN
        // Phase D: silent link after a request
        begin
            int n;
            exp_timeouts = 1;
            tick();
            set_submit(32'h5555_AAAA, 8'h33, 1'b1);
            push_tx(32'h5555_AAAA, 8'h33);
            tick();
            set_submit(32'h0, 8'h0, 1'b0);
            wait_tx_done("tx_to");
            n = 0;
            while (!job_timeout && n < 300) begin
                @(negedge clk_100mhz);
                n++;
            end
            check("timeout_cycles", n, 100);
            check("timeout_result", ibm_measurement_result, '0);
            wait_idle("idle_to");
        end
`endif

        repeat (5) @(negedge clk_100mhz);
        check("tx_q_empty", tx_q.size(), 0);
        check("exp_q_empty", exp_q.size(), 0);
        check("complete_count", n_complete, 7);
        check("timeout_count", n_timeouts, exp_timeouts);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
